// File: rtl/bias_max_pkg.sv
// Shared types and constants for the bias maximum reduction path.
package bias_max_pkg;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  localparam int unsigned COUNT_WIDTH_DEFAULT = 8;

  function automatic int unsigned count_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  localparam int unsigned COUNT_MAX = count_max(COUNT_WIDTH_DEFAULT);

endpackage

// File: rtl/bias_max_update.sv
// Next-value logic for one active-maximum lane: folds one tagged bias into
// the running (maximum, activation) pair; ties keep the earlier value.
module bias_max_update #(
  parameter int unsigned NUMBER_SIZE = 4
) (
  input  logic [NUMBER_SIZE-1:0] acc_max,
  input  logic                   acc_act,
  input  logic [NUMBER_SIZE-1:0] in_number,
  input  logic                   in_activation,
  output logic [NUMBER_SIZE-1:0] next_max,
  output logic                   next_act
);

  always_comb begin
    next_max = acc_max;
    next_act = acc_act | in_activation;
    if (in_activation && (!acc_act || ($signed(in_number) > $signed(acc_max)))) begin
      next_max = in_number;
    end
  end

endmodule

// File: rtl/bias_max_accumulator.sv
// Packet-level active maximum: accumulates one bias per accepted beat and
// presents the registered result over a valid/ready handshake.
module bias_max_accumulator
  import bias_max_pkg::*;
#(
  parameter int unsigned NUMBER_SIZE = 4,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUMBER_SIZE-1:0] in_number,
  input  logic                   in_activation,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUMBER_SIZE-1:0] out_maximum,
  output logic                   out_maximum_activation,
  output logic [COUNT_WIDTH-1:0] out_count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(count_max(COUNT_WIDTH));

  state_t                 state_q, state_d;
  logic [NUMBER_SIZE-1:0] acc_max_q, acc_max_d;
  logic                   acc_act_q, acc_act_d;
  logic [COUNT_WIDTH-1:0] acc_count_q, acc_count_d;
  logic [NUMBER_SIZE-1:0] out_max_q, out_max_d;
  logic                   out_act_q, out_act_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;

  logic [NUMBER_SIZE-1:0] upd_max;
  logic                   upd_act;
  logic [COUNT_WIDTH-1:0] upd_count;
  logic                   accept;

  bias_max_update #(
    .NUMBER_SIZE(NUMBER_SIZE)
  ) u_update (
    .acc_max      (acc_max_q),
    .acc_act      (acc_act_q),
    .in_number    (in_number),
    .in_activation(in_activation),
    .next_max     (upd_max),
    .next_act     (upd_act)
  );

  always_comb begin
    accept      = in_valid && (state_q == ACCUM);
    upd_count   = (in_activation && (acc_count_q != CNT_MAX))
                  ? acc_count_q + COUNT_WIDTH'(1) : acc_count_q;
    state_d     = state_q;
    acc_max_d   = acc_max_q;
    acc_act_d   = acc_act_q;
    acc_count_d = acc_count_q;
    out_max_d   = out_max_q;
    out_act_d   = out_act_q;
    out_count_d = out_count_q;
    if (accept) begin
      if (in_last) begin
        // The last beat bypasses the accumulator straight into the result.
        out_max_d   = upd_max;
        out_act_d   = upd_act;
        out_count_d = upd_count;
        acc_max_d   = '0;
        acc_act_d   = 1'b0;
        acc_count_d = '0;
        state_d     = HOLD;
      end else begin
        acc_max_d   = upd_max;
        acc_act_d   = upd_act;
        acc_count_d = upd_count;
      end
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_max_q   <= '0;
      acc_act_q   <= 1'b0;
      acc_count_q <= '0;
      out_max_q   <= '0;
      out_act_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_max_q   <= acc_max_d;
      acc_act_q   <= acc_act_d;
      acc_count_q <= acc_count_d;
      out_max_q   <= out_max_d;
      out_act_q   <= out_act_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready               = (state_q == ACCUM);
  assign out_valid              = (state_q == HOLD);
  assign out_maximum            = out_max_q;
  assign out_maximum_activation = out_act_q;
  assign out_count              = out_count_q;

endmodule

// File: tb/tb_bias_max_accumulator.sv
// Bench for bias_max_accumulator: two instances (8-bit and 2-bit counters)
// share stimulus and are checked every cycle against a packet-level model.
module tb_bias_max_accumulator;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [3:0] in_number;
  logic              in_activation;
  logic              in_last;
  logic              out_ready;

  logic       in_ready0, out_valid0, out_act0;
  logic [3:0] out_max0;
  logic [7:0] out_count0;
  logic       in_ready1, out_valid1, out_act1;
  logic [3:0] out_max1;
  logic [1:0] out_count1;

  int npass = 0;
  int ntotal = 0;

  bias_max_accumulator #(.NUMBER_SIZE(4), .COUNT_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_number(in_number), .in_activation(in_activation), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_maximum(out_max0),
    .out_maximum_activation(out_act0), .out_count(out_count0)
  );

  bias_max_accumulator #(.NUMBER_SIZE(4), .COUNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_number(in_number), .in_activation(in_activation), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_maximum(out_max1),
    .out_maximum_activation(out_act1), .out_count(out_count1)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int got, input int exp);
    ntotal++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endfunction

  // Packet-level reference: collect accepted beats, reduce on the last one.
  int q_val[$];
  bit q_act[$];
  bit exp_hold = 1'b0;
  int exp_max = 0;
  int exp_act = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q_val.delete();
        q_act.delete();
        exp_hold = 1'b0;
      end else if (!exp_hold) begin
        if (in_valid) begin
          q_val.push_back(int'(in_number));
          q_act.push_back(in_activation);
          if (in_last) begin
            int m, n;
            bit found;
            m = 0; n = 0; found = 1'b0;
            foreach (q_val[k]) begin
              if (q_act[k]) begin
                n++;
                if (!found || q_val[k] > m) m = q_val[k];
                found = 1'b1;
              end
            end
            exp_max  = m;
            exp_act  = int'(found);
            exp_cnt0 = (n > 255) ? 255 : n;
            exp_cnt1 = (n > 3) ? 3 : n;
            q_val.delete();
            q_act.delete();
            exp_hold = 1'b1;
          end
        end
      end else if (out_ready) begin
        exp_hold = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("in_ready0", int'(in_ready0), int'(!exp_hold));
      check("out_valid0", int'(out_valid0), int'(exp_hold));
      check("in_ready1", int'(in_ready1), int'(!exp_hold));
      check("out_valid1", int'(out_valid1), int'(exp_hold));
      if (exp_hold) begin
        check("out_max0", int'($signed(out_max0)), exp_max);
        check("out_act0", int'(out_act0), exp_act);
        check("out_count0", int'(out_count0), exp_cnt0);
        check("out_max1", int'($signed(out_max1)), exp_max);
        check("out_act1", int'(out_act1), exp_act);
        check("out_count1", int'(out_count1), exp_cnt1);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v, input bit a, input bit last);
    in_valid      = 1'b1;
    in_number     = 4'(v);
    in_activation = a;
    in_last       = last;
    cycle();
    in_valid = 1'b0;
  endtask

  // Literal result checks on the 8-bit instance, then consume the result.
  task automatic take(input string nm, input int m, input int a, input int c);
    check({nm, "_valid"}, int'(out_valid0), 1);
    check({nm, "_max"}, int'($signed(out_max0)), m);
    check({nm, "_act"}, int'(out_act0), a);
    check({nm, "_count"}, int'(out_count0), c);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check({nm, "_drop"}, int'(out_valid0), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_number = '0; in_activation = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    check("rst_in_ready", int'(in_ready0), 1);
    check("rst_out_valid", int'(out_valid0), 0);
    check("rst_max", int'(out_max0), 0);
    check("rst_act", int'(out_act0), 0);
    check("rst_count", int'(out_count0), 0);
    rst = 1'b0;
    cycle();

    beat(3, 1, 0); beat(-2, 1, 0); beat(7, 1, 0); beat(5, 1, 1);
    take("pkt_a", 7, 1, 4);

    beat(7, 0, 0); beat(-8, 1, 0); beat(-3, 1, 1);
    take("pkt_b", -3, 1, 2);

    beat(4, 0, 0); beat(6, 0, 1);
    take("pkt_none", 0, 0, 0);

    // Backpressure: a beat offered throughout HOLD must wait until after release.
    beat(1, 1, 1);
    in_valid = 1'b1; in_number = 4'sd5; in_activation = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_in_ready", int'(in_ready0), 0);
      check("bp_max", int'($signed(out_max0)), 1);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("bp_released", int'(in_ready0), 1);
    cycle();
    in_valid = 1'b0;
    take("bp_next", 5, 1, 1);

    beat(1, 1, 0); beat(2, 1, 0); beat(2, 1, 0); beat(-1, 1, 0); beat(0, 1, 1);
    check("sat2_count", int'(out_count1), 3);
    check("sat2_max", int'($signed(out_max1)), 2);
    take("sat_w8", 2, 1, 5);

    for (int i = 0; i < 299; i++) beat(int'($urandom_range(0, 15)) - 8, 1, 0);
    beat(-8, 1, 1);
    check("sat8_count", int'(out_count0), 255);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    beat(6, 1, 0); beat(2, 1, 0);
    rst = 1'b1;
    #2;
    check("midrst_in_ready", int'(in_ready0), 1);
    check("midrst_out_valid", int'(out_valid0), 0);
    cycle();
    rst = 1'b0;
    beat(-5, 1, 1);
    take("after_rst", -5, 1, 1);

    for (int i = 0; i < 600; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_number     = 4'($urandom);
      in_activation = $urandom_range(0, 1) == 1;
      in_last       = ($urandom_range(0, 4) == 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      if (i == 300) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end else begin
        cycle();
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
